// File: rtl/defect_qualify_pkg.sv
// Shared types and constants for the defect sensor qualifier.
package defect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUAL  = 2'd1,
    LATCH = 2'd2
  } chan_state_e;

  localparam int unsigned CH_N = 0;
  localparam int unsigned CH_P = 1;
  localparam int unsigned CH_K = 2;
  localparam int unsigned N_CH = 3;

  // Number of channels asserting a qualification pulse this cycle.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/defect_qualify_if.sv
// Sensor inputs, clear request and qualified outputs of the defect qualifier.
interface defect_qualify_if #(
  parameter int unsigned EVT_W = 8
);

  logic             sns_n;
  logic             sns_p;
  logic             sns_k;
  logic             clr;
  logic             en_N;
  logic             en_P;
  logic             en_K;
  logic [EVT_W-1:0] evt_cnt;

  modport master (
    output sns_n, sns_p, sns_k, clr,
    input  en_N, en_P, en_K, evt_cnt
  );

  modport slave (
    input  sns_n, sns_p, sns_k, clr,
    output en_N, en_P, en_K, evt_cnt
  );

endinterface

// File: rtl/defect_qualify_chan.sv
// One defect channel: two-FF synchroniser, debounce counter and sticky flag FSM.
module defect_chan
  import defect_pkg::*;
#(
  parameter int unsigned DEB_W   = 20,
  parameter int unsigned DEB_CNT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic sns,
  input  logic clr,
  output logic flag,
  output logic qual_pulse_c
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

  logic             sync1;
  logic             s;
  chan_state_e      state;
  chan_state_e      state_nx;
  logic [DEB_W-1:0] cnt;
  logic [DEB_W-1:0] cnt_nx;
  logic             flag_nx;

  // Bring the asynchronous sensor line into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= sns;
      s     <= sync1;
    end
  end

  // State, debounce counter and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      flag  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      flag  <= flag_nx;
    end
  end

  // Debounce: count consecutive synced-high cycles, latch until cleared with sensor low.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    flag_nx      = flag;
    qual_pulse_c = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nx = QUAL;
          cnt_nx   = DEB_W'(1);
        end else begin
          cnt_nx   = '0;
        end
      end
      QUAL: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx     = LATCH;
          flag_nx      = 1'b1;
          qual_pulse_c = 1'b1;
        end else begin
          cnt_nx = cnt + DEB_W'(1);
        end
      end
      LATCH: begin
        flag_nx = 1'b1;
        // A clear is only honoured once the defect has gone away.
        if (clr && !s) begin
          state_nx = IDLE;
          flag_nx  = 1'b0;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        flag_nx  = 1'b0;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/defect_qualify.sv
// Three-channel defect qualifier with a saturating qualified-event counter.
module defect_qualify
  import defect_pkg::*;
#(
  parameter int unsigned DEB_W   = 20,
  parameter int unsigned DEB_CNT = 500000,
  parameter int unsigned EVT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  defect_qualify_if.slave  bus
);

  localparam int unsigned    SUM_W   = EVT_W + 2;
  localparam logic [SUM_W-1:0] EVT_MAX = SUM_W'({EVT_W{1'b1}});

  logic [N_CH-1:0]  sns_vec;
  logic [N_CH-1:0]  flag;
  logic [N_CH-1:0]  qual_c;
  logic [EVT_W-1:0] evt_q;
  logic [SUM_W-1:0] evt_sum_c;
  logic [EVT_W-1:0] evt_nx_c;

  assign sns_vec[CH_N] = bus.sns_n;
  assign sns_vec[CH_P] = bus.sns_p;
  assign sns_vec[CH_K] = bus.sns_k;

  // Independent qualifier per sensor.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    defect_chan #(
      .DEB_W   (DEB_W),
      .DEB_CNT (DEB_CNT)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .sns          (sns_vec[i]),
      .clr          (bus.clr),
      .flag         (flag[i]),
      .qual_pulse_c (qual_c[i])
    );
  end

  // Add this cycle's qualifications, clamping at the counter's maximum.
  always_comb begin
    evt_sum_c = SUM_W'(evt_q) + SUM_W'(popcount3(qual_c));
    evt_nx_c  = evt_q;
    if (evt_sum_c > EVT_MAX) begin
      evt_nx_c = EVT_MAX[EVT_W-1:0];
    end else begin
      evt_nx_c = evt_sum_c[EVT_W-1:0];
    end
  end

  // Event counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_nx_c;
    end
  end

  assign bus.en_N    = flag[CH_N];
  assign bus.en_P    = flag[CH_P];
  assign bus.en_K    = flag[CH_K];
  assign bus.evt_cnt = evt_q;

endmodule

// File: tb/tb_defect_qualify.sv
// Scoreboard bench for defect_qualify with short debounce and a 2-bit event counter.
module tb_defect_qualify;

  localparam int unsigned DEB_W   = 3;
  localparam int unsigned DEB_CNT = 4;
  localparam int unsigned EVT_W   = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  defect_qualify_if #(.EVT_W(EVT_W)) bus ();

  defect_qualify #(
    .DEB_W   (DEB_W),
    .DEB_CNT (DEB_CNT),
    .EVT_W   (EVT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string            tag;
    logic [2:0]       en;
    logic [EVT_W-1:0] evt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [2:0] en, input logic [EVT_W-1:0] evt);
    exp_t e;
    e.tag = tag;
    e.en  = en;
    e.evt = evt;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".en"}, {29'b0, bus.en_N, bus.en_P, bus.en_K}, 32'(e.en));
    chk({e.tag, ".evt"}, 32'(bus.evt_cnt), 32'(e.evt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expectation for the outputs after the next clock edge.
  task automatic step(input string tag, input logic [2:0] en, input logic [EVT_W-1:0] evt);
    push_exp(tag, en, evt);
    tick();
    pop_chk();
  endtask

  // Expectation for the outputs right now, without an edge.
  task automatic now_chk(input string tag, input logic [2:0] en, input logic [EVT_W-1:0] evt);
    push_exp(tag, en, evt);
    pop_chk();
  endtask

  task automatic set_sns(input logic [2:0] v);
    {bus.sns_n, bus.sns_p, bus.sns_k} = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    bus.clr = 1'b0;
    set_sns(3'b111);
    #3;
    now_chk("rst_hold", 3'b000, 2'd0);
    tick();
    now_chk("rst_edge", 3'b000, 2'd0);

    // Release reset with only N high: en_N on edge 6.
    set_sns(3'b100);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step("n_wait", 3'b000, 2'd0);
    step("n_qual", 3'b100, 2'd1);

    // P high for 3 sampled cycles then low: rejected.
    set_sns(3'b110);
    for (int i = 0; i < 3; i++) step("p_glitch_hi", 3'b100, 2'd1);
    set_sns(3'b100);
    for (int i = 0; i < 6; i++) step("p_glitch_lo", 3'b100, 2'd1);
    set_sns(3'b110);
    for (int i = 0; i < 5; i++) step("p_wait", 3'b100, 2'd1);
    step("p_qual", 3'b110, 2'd2);

    // K sticky and clear behaviour.
    set_sns(3'b111);
    for (int i = 0; i < 5; i++) step("k_wait", 3'b110, 2'd2);
    step("k_qual", 3'b111, 2'd3);
    set_sns(3'b110);
    for (int i = 0; i < 4; i++) step("k_sticky", 3'b111, 2'd3);
    set_sns(3'b111);
    for (int i = 0; i < 2; i++) step("k_rehi", 3'b111, 2'd3);
    bus.clr = 1'b1;
    for (int i = 0; i < 3; i++) step("k_clr_hi", 3'b111, 2'd3);
    bus.clr = 1'b0;
    set_sns(3'b110);
    for (int i = 0; i < 2; i++) step("k_drop", 3'b111, 2'd3);
    bus.clr = 1'b1;
    step("k_clr", 3'b110, 2'd3);
    bus.clr = 1'b0;

    // Async reset while N and P are latched.
    #1 rst = 1'b0;
    #1 now_chk("rst_latch", 3'b000, 2'd0);
    set_sns(3'b000);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 3'b000, 2'd0);

    // Simultaneous qualification, then saturation.
    set_sns(3'b111);
    for (int i = 0; i < 5; i++) step("all_wait", 3'b000, 2'd0);
    step("all_qual", 3'b111, 2'd3);
    set_sns(3'b000);
    for (int i = 0; i < 2; i++) step("all_drop", 3'b111, 2'd3);
    bus.clr = 1'b1;
    step("all_clr", 3'b000, 2'd3);
    bus.clr = 1'b0;
    set_sns(3'b100);
    for (int i = 0; i < 5; i++) step("sat_wait", 3'b000, 2'd3);
    step("sat_qual", 3'b100, 2'd3);

    // Async reset while P is mid-qualification; both restart from scratch.
    set_sns(3'b110);
    for (int i = 0; i < 3; i++) step("p_midq", 3'b100, 2'd3);
    #1 rst = 1'b0;
    #1 now_chk("rst_qual", 3'b000, 2'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) step("restart_wait", 3'b000, 2'd0);
    step("restart_qual", 3'b110, 2'd2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
